// File: rtl/stereo_wr_arbiter_pkg.sv
// Shared types and defaults for the stereo frame-buffer write arbiter.
package stereo_arb_pkg;

    localparam int DEF_ADDR_W      = 19;
    localparam int DEF_DATA_W      = 8;
    localparam int DEF_FRAME_WORDS = 480000;   // 800*600, also the right-bank base
    localparam int DEF_FIFO_DEPTH  = 4;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } port_id_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        L_DONE = 2'd1,
        R_DONE = 2'd2
    } pair_state_t;

    // Entry layout at the default widths; the top builds the same layout
    // from its own parameters so non-default widths stay consistent.
    typedef struct packed {
        logic                  eof;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } pix_entry_t;

endpackage

// File: rtl/stereo_wr_arbiter_if.sv
// Camera pixel inputs and frame RAM write port of the stereo arbiter.
interface stereo_wr_arbiter_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
);
    logic              l_valid;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_data;
    logic              l_eof;
    logic              r_valid;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_eof;
    logic              mem_we;
    logic [ADDR_W:0]   mem_addr;
    logic [DATA_W-1:0] mem_data;

    // Capture side / environment: drives pixels, observes the RAM port.
    modport master (
        output l_valid, l_addr, l_data, l_eof,
        output r_valid, r_addr, r_data, r_eof,
        input  mem_we, mem_addr, mem_data
    );

    // Arbiter side.
    modport slave (
        input  l_valid, l_addr, l_data, l_eof,
        input  r_valid, r_addr, r_data, r_eof,
        output mem_we, mem_addr, mem_data
    );
endinterface

// File: rtl/stereo_wr_arbiter_pix_fifo.sv
// Small synchronous FIFO; a pop and a push in the same cycle are legal
// even when full (the popped slot takes the new entry).
module pix_fifo #(
    parameter int WIDTH = 28,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]     CNT_ZERO = (AW+1)'(0);
    localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_en_s;
    logic             pop_en_s;

    assign full      = (count_r == FULL_CNT);
    assign empty     = (count_r == CNT_ZERO);
    assign pop_data  = mem_r[rd_ptr_r];
    assign pop_en_s  = pop && !empty;
    assign push_en_s = push && (!full || pop_en_s);

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_en_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_en_s, pop_en_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/stereo_wr_arbiter.sv
// Round-robin write arbiter sharing one frame RAM port between the left and
// right camera streams. Right pixels land in the upper bank (addr+FRAME_WORDS).
// Optional feature macro: STEREO_ARB_DROP_CNT_EN adds per-port drop counters.
module stereo_wr_arbiter
    import stereo_arb_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int FRAME_WORDS = DEF_FRAME_WORDS,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic                 clk_50,
    input  logic                 reset,
    stereo_wr_arbiter_if.slave   bus,
    input  logic                 clr_flags,
    output logic                 pair_done,
    output logic                 l_ovf,
    output logic                 r_ovf,
    output logic                 addr_err
`ifdef STEREO_ARB_DROP_CNT_EN
    ,
    output logic [15:0]          l_drop_cnt,
    output logic [15:0]          r_drop_cnt
`endif
);
    localparam logic [ADDR_W:0] FRAME_WORDS_W = (ADDR_W+1)'(FRAME_WORDS);

    typedef struct packed {
        logic              eof;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    entry_t      l_in_s, r_in_s, l_head_s, r_head_s, gnt_entry_s;
    logic        l_full_s, l_empty_s, r_full_s, r_empty_s;
    logic        l_pop_s, r_pop_s;
    logic        l_in_range_s, r_in_range_s;
    logic        l_push_s, r_push_s;
    logic        l_ovf_set_s, r_ovf_set_s;
    logic        l_aerr_s, r_aerr_s;
    logic        gnt_valid_s;
    port_id_t    gnt_port_s;
    logic [ADDR_W:0] gnt_addr_s;

    port_id_t        last_gnt_r;
    pair_state_t     state_r;
    logic            mem_we_r;
    logic [ADDR_W:0] mem_addr_r;
    logic [DATA_W-1:0] mem_data_r;
    logic            pair_done_r;
    logic            l_ovf_r, r_ovf_r, addr_err_r;

    assign l_in_s = '{eof: bus.l_eof, addr: bus.l_addr, data: bus.l_data};
    assign r_in_s = '{eof: bus.r_eof, addr: bus.r_addr, data: bus.r_data};

    assign l_in_range_s = ({1'b0, bus.l_addr} < FRAME_WORDS_W);
    assign r_in_range_s = ({1'b0, bus.r_addr} < FRAME_WORDS_W);

    // A full FIFO still accepts a push when it is popped in the same cycle.
    assign l_push_s    = bus.l_valid && l_in_range_s && (!l_full_s || l_pop_s);
    assign r_push_s    = bus.r_valid && r_in_range_s && (!r_full_s || r_pop_s);
    assign l_ovf_set_s = bus.l_valid && l_in_range_s && l_full_s && !l_pop_s;
    assign r_ovf_set_s = bus.r_valid && r_in_range_s && r_full_s && !r_pop_s;
    assign l_aerr_s    = bus.l_valid && !l_in_range_s;
    assign r_aerr_s    = bus.r_valid && !r_in_range_s;

    pix_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_l_fifo (
        .clk       (clk_50),
        .rst_n     (reset),
        .push      (l_push_s),
        .push_data (l_in_s),
        .pop       (l_pop_s),
        .pop_data  (l_head_s),
        .full      (l_full_s),
        .empty     (l_empty_s)
    );

    pix_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_r_fifo (
        .clk       (clk_50),
        .rst_n     (reset),
        .push      (r_push_s),
        .push_data (r_in_s),
        .pop       (r_pop_s),
        .pop_data  (r_head_s),
        .full      (r_full_s),
        .empty     (r_empty_s)
    );

    // Round-robin grant: a lone non-empty port wins, contention alternates.
    always_comb begin
        l_pop_s = 1'b0;
        r_pop_s = 1'b0;
        case ({l_empty_s, r_empty_s})
            2'b01: l_pop_s = 1'b1;
            2'b10: r_pop_s = 1'b1;
            2'b00: begin
                if (last_gnt_r == RIGHT) begin
                    l_pop_s = 1'b1;
                end else begin
                    r_pop_s = 1'b1;
                end
            end
            default: begin
                l_pop_s = 1'b0;
                r_pop_s = 1'b0;
            end
        endcase
    end

    // Selected entry and its bank-adjusted RAM address.
    always_comb begin
        gnt_valid_s = l_pop_s || r_pop_s;
        if (r_pop_s) begin
            gnt_port_s  = RIGHT;
            gnt_entry_s = r_head_s;
            gnt_addr_s  = {1'b0, r_head_s.addr} + FRAME_WORDS_W;
        end else begin
            gnt_port_s  = LEFT;
            gnt_entry_s = l_head_s;
            gnt_addr_s  = {1'b0, l_head_s.addr};
        end
    end

    // Write-port register, grant history and frame-pair FSM.
    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_data_r  <= '0;
            last_gnt_r  <= RIGHT;
            state_r     <= IDLE;
            pair_done_r <= 1'b0;
        end else begin
            mem_we_r    <= gnt_valid_s;
            pair_done_r <= 1'b0;
            if (gnt_valid_s) begin
                mem_addr_r <= gnt_addr_s;
                mem_data_r <= gnt_entry_s.data;
                last_gnt_r <= gnt_port_s;
                if (gnt_entry_s.eof) begin
                    case (state_r)
                        IDLE: begin
                            state_r <= (gnt_port_s == LEFT) ? L_DONE : R_DONE;
                        end
                        L_DONE: begin
                            if (gnt_port_s == RIGHT) begin
                                state_r     <= IDLE;
                                pair_done_r <= 1'b1;
                            end else begin
                                state_r <= L_DONE;
                            end
                        end
                        R_DONE: begin
                            if (gnt_port_s == LEFT) begin
                                state_r     <= IDLE;
                                pair_done_r <= 1'b1;
                            end else begin
                                state_r <= R_DONE;
                            end
                        end
                        default: state_r <= IDLE;
                    endcase
                end
            end
        end
    end

    // Sticky error flags; a set in the clearing cycle takes priority.
    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            l_ovf_r    <= 1'b0;
            r_ovf_r    <= 1'b0;
            addr_err_r <= 1'b0;
        end else begin
            l_ovf_r    <= l_ovf_set_s || (l_ovf_r && !clr_flags);
            r_ovf_r    <= r_ovf_set_s || (r_ovf_r && !clr_flags);
            addr_err_r <= l_aerr_s || r_aerr_s || (addr_err_r && !clr_flags);
        end
    end

`ifdef STEREO_ARB_DROP_CNT_EN
    logic [15:0] l_drop_cnt_r, r_drop_cnt_r;
    logic        l_drop_s, r_drop_s;

    assign l_drop_s = l_ovf_set_s || l_aerr_s;
    assign r_drop_s = r_ovf_set_s || r_aerr_s;

    // Saturating drop counters; a drop in the clearing cycle counts as one.
    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            l_drop_cnt_r <= 16'd0;
            r_drop_cnt_r <= 16'd0;
        end else begin
            if (clr_flags) begin
                l_drop_cnt_r <= l_drop_s ? 16'd1 : 16'd0;
                r_drop_cnt_r <= r_drop_s ? 16'd1 : 16'd0;
            end else begin
                if (l_drop_s && (l_drop_cnt_r != 16'hFFFF)) begin
                    l_drop_cnt_r <= l_drop_cnt_r + 16'd1;
                end else begin
                    l_drop_cnt_r <= l_drop_cnt_r;
                end
                if (r_drop_s && (r_drop_cnt_r != 16'hFFFF)) begin
                    r_drop_cnt_r <= r_drop_cnt_r + 16'd1;
                end else begin
                    r_drop_cnt_r <= r_drop_cnt_r;
                end
            end
        end
    end

    assign l_drop_cnt = l_drop_cnt_r;
    assign r_drop_cnt = r_drop_cnt_r;
`endif

    assign bus.mem_we   = mem_we_r;
    assign bus.mem_addr = mem_addr_r;
    assign bus.mem_data = mem_data_r;
    assign pair_done    = pair_done_r;
    assign l_ovf        = l_ovf_r;
    assign r_ovf        = r_ovf_r;
    assign addr_err     = addr_err_r;

endmodule

// File: tb/tb_stereo_wr_arbiter.sv
// Directed self-checking bench for stereo_wr_arbiter.
module tb_stereo_wr_arbiter;
    logic clk_50 = 1'b0;
    logic reset;
    logic clr_flags;
    logic pair_done, l_ovf, r_ovf, addr_err;
`ifdef STEREO_ARB_DROP_CNT_EN
    logic [15:0] l_drop_cnt, r_drop_cnt;
`endif

    int errors = 0;
    int checks = 0;

    stereo_wr_arbiter_if #(.ADDR_W(19), .DATA_W(8)) bus ();

    stereo_wr_arbiter #(
        .ADDR_W(19), .DATA_W(8), .FRAME_WORDS(480000), .FIFO_DEPTH(4)
    ) dut (
        .clk_50    (clk_50),
        .reset     (reset),
        .bus       (bus),
        .clr_flags (clr_flags),
        .pair_done (pair_done),
        .l_ovf     (l_ovf),
        .r_ovf     (r_ovf),
        .addr_err  (addr_err)
`ifdef STEREO_ARB_DROP_CNT_EN
        ,
        .l_drop_cnt(l_drop_cnt),
        .r_drop_cnt(r_drop_cnt)
`endif
    );

    always #5 clk_50 = ~clk_50;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_50);
        #1;
    endtask

    task automatic set_l(input logic v, input logic [18:0] a, input logic [7:0] d, input logic e);
        bus.l_valid = v; bus.l_addr = a; bus.l_data = d; bus.l_eof = e;
    endtask

    task automatic set_r(input logic v, input logic [18:0] a, input logic [7:0] d, input logic e);
        bus.r_valid = v; bus.r_addr = a; bus.r_data = d; bus.r_eof = e;
    endtask

    task automatic idle();
        set_l(1'b0, 19'd0, 8'd0, 1'b0);
        set_r(1'b0, 19'd0, 8'd0, 1'b0);
    endtask

    int exp_a [6] = '{0, 480010, 1, 480011, 2, 480012};
    int exp_d [6] = '{16, 138, 17, 139, 18, 140};
    int writes;
    int pulses;
    int pulse_cycle;
    logic [19:0] wa;
    logic [19:0] off;
    logic [7:0]  wd;

    initial begin
        reset = 1'b1;
        clr_flags = 1'b0;
        idle();
        #2 reset = 1'b0;
        #1;
        chk("rst_async_we", bus.mem_we, 0);
        tick(); tick();
        chk("rst_we", bus.mem_we, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_data", bus.mem_data, 0);
        chk("rst_pair_done", pair_done, 0);
        chk("rst_flags", {l_ovf, r_ovf, addr_err}, 0);
        reset = 1'b1;
        tick();

        // Single left pixel: write appears after the second edge.
        set_l(1'b1, 19'd5, 8'hAA, 1'b0);
        tick();
        idle();
        chk("t1_we_early", bus.mem_we, 0);
        tick();
        chk("t1_we", bus.mem_we, 1);
        chk("t1_addr", bus.mem_addr, 5);
        chk("t1_data", bus.mem_data, 8'hAA);
        tick();
        chk("t1_we_off", bus.mem_we, 0);
        chk("t1_addr_hold", bus.mem_addr, 5);

        // Single right pixel lands in the upper bank.
        set_r(1'b1, 19'd5, 8'h3C, 1'b0);
        tick();
        idle();
        tick();
        chk("t2_we", bus.mem_we, 1);
        chk("t2_addr", bus.mem_addr, 480005);
        chk("t2_data", bus.mem_data, 8'h3C);
        chk("t2_flags", {l_ovf, r_ovf, addr_err}, 0);

        // Three cycles of contention: strict alternation starting with left.
        for (int i = 0; i < 8; i++) begin
            if (i < 3) begin
                set_l(1'b1, 19'(i), 8'(i + 16), 1'b0);
                set_r(1'b1, 19'(i + 10), 8'(i + 138), 1'b0);
            end else begin
                idle();
            end
            tick();
            if (i >= 1 && i <= 6) begin
                chk("t3_we", bus.mem_we, 1);
                chk("t3_addr", bus.mem_addr, 32'(exp_a[i-1]));
                chk("t3_data", bus.mem_data, 32'(exp_d[i-1]));
            end else begin
                chk("t3_we_idle", bus.mem_we, 0);
            end
        end
        chk("t3_ovf", {l_ovf, r_ovf}, 0);

        // Twelve cycles of both ports: 2 left and 3 right drops, 19 writes.
        writes = 0;
        for (int c = 0; c < 40; c++) begin
            if (c < 12) begin
                set_l(1'b1, 19'(c), 8'(c + 16), 1'b0);
                set_r(1'b1, 19'(c), 8'(c + 128), 1'b0);
            end else begin
                idle();
            end
            tick();
            if (bus.mem_we) begin
                writes++;
                wa = bus.mem_addr;
                if (wa >= 20'd480000) begin
                    off = wa - 20'd480000;
                    wd  = 8'(off) + 8'h80;
                end else begin
                    off = wa;
                    wd  = 8'(off) + 8'h10;
                end
                chk("t4_addr_range", {31'd0, (off < 20'd12)}, 1);
                chk("t4_data", bus.mem_data, wd);
            end
        end
        chk("t4_writes", writes, 19);
        chk("t4_l_ovf", l_ovf, 1);
        chk("t4_r_ovf", r_ovf, 1);
        chk("t4_addr_err", addr_err, 0);
`ifdef STEREO_ARB_DROP_CNT_EN
        chk("t4_l_drop", l_drop_cnt, 2);
        chk("t4_r_drop", r_drop_cnt, 3);
`endif
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("t4_clr", {l_ovf, r_ovf, addr_err}, 0);
`ifdef STEREO_ARB_DROP_CNT_EN
        chk("t4_drop_clr", {l_drop_cnt, r_drop_cnt}, 0);
`endif

        // Left eof, right eof 20 cycles later: one pulse on the right write.
        pulses = 0;
        pulse_cycle = -1;
        for (int c = 0; c < 30; c++) begin
            if (c == 0) set_l(1'b1, 19'd100, 8'h01, 1'b1);
            else if (c == 20) set_r(1'b1, 19'd100, 8'h02, 1'b1);
            else idle();
            tick();
            if (pair_done) begin
                pulses++;
                pulse_cycle = c;
                chk("t5_pulse_we", bus.mem_we, 1);
                chk("t5_pulse_addr", bus.mem_addr, 480100);
            end
        end
        chk("t5_pulses", pulses, 1);
        chk("t5_pulse_cycle", pulse_cycle, 21);

        // Left, left, right: the second left supersedes, still one pulse.
        pulses = 0;
        pulse_cycle = -1;
        for (int c = 0; c < 25; c++) begin
            if (c == 0) set_l(1'b1, 19'd200, 8'h03, 1'b1);
            else if (c == 5) set_l(1'b1, 19'd201, 8'h04, 1'b1);
            else if (c == 10) set_r(1'b1, 19'd202, 8'h05, 1'b1);
            else idle();
            tick();
            if (pair_done) begin
                pulses++;
                pulse_cycle = c;
                chk("t5b_pulse_addr", bus.mem_addr, 480202);
            end
        end
        chk("t5b_pulses", pulses, 1);
        chk("t5b_pulse_cycle", pulse_cycle, 11);

        // Out-of-range address: dropped, addr_err only.
        set_l(1'b1, 19'd480000, 8'h55, 1'b0);
        tick();
        idle();
        chk("t6_we0", bus.mem_we, 0);
        chk("t6_addr_err", addr_err, 1);
        tick();
        chk("t6_we1", bus.mem_we, 0);
        chk("t6_ovf", {l_ovf, r_ovf}, 0);
`ifdef STEREO_ARB_DROP_CNT_EN
        chk("t6_l_drop", l_drop_cnt, 1);
`endif
        set_l(1'b1, 19'd524287, 8'h56, 1'b0);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        idle();
        chk("t6_set_wins", addr_err, 1);
`ifdef STEREO_ARB_DROP_CNT_EN
        chk("t6_drop_set_wins", l_drop_cnt, 1);
`endif
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("t6_clr", addr_err, 0);

        // Asynchronous reset while both FIFOs still hold pixels.
        set_l(1'b1, 19'd0, 8'h10, 1'b0); set_r(1'b1, 19'd0, 8'h80, 1'b0);
        tick();
        set_l(1'b1, 19'd1, 8'h11, 1'b0); set_r(1'b1, 19'd1, 8'h81, 1'b0);
        tick();
        set_l(1'b1, 19'd480000, 8'h12, 1'b0); set_r(1'b1, 19'd2, 8'h82, 1'b0);
        tick();
        idle();
        tick();
        chk("t7_pre_we", bus.mem_we, 1);
        chk("t7_pre_addr_err", addr_err, 1);
        #2 reset = 1'b0;
        #1;
        chk("t7_rst_we", bus.mem_we, 0);
        chk("t7_rst_addr", bus.mem_addr, 0);
        chk("t7_rst_data", bus.mem_data, 0);
        chk("t7_rst_flags", {pair_done, l_ovf, r_ovf, addr_err}, 0);
        tick();
        reset = 1'b1;
        writes = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.mem_we) writes++;
        end
        chk("t7_no_writes", writes, 0);
        set_l(1'b1, 19'd7, 8'h77, 1'b0);
        tick();
        idle();
        tick();
        chk("t7_new_we", bus.mem_we, 1);
        chk("t7_new_addr", bus.mem_addr, 7);
        chk("t7_new_data", bus.mem_data, 8'h77);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/stereo_wr_arbiter.md
Name: stereo_wr_arbiter

Overview:
- Shares the single write port of the stereo frame buffer between the left and right camera pixel streams.
- Each stream is buffered in a small FIFO. Grants are round-robin, and the right camera is offset into the upper half of the buffer.
- Signals when a complete left and right frame pair has been written, so the reader can swap or process.
- Sits between the two camera capture blocks, already in the clk_50 domain, and the frame RAM write port.

Parameters:
- ADDR_W, 19, per-camera pixel address width
- DATA_W, 8, pixel width
- FRAME_WORDS, 480000, pixels per frame (800*600); right-bank base offset
- FIFO_DEPTH, 4, per-port FIFO entries; power of 2, at least 2

Ports:
- clk_50  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- l_valid  in  1  left pixel valid, one-cycle qualifier
- l_addr  in  ADDR_W  left pixel address
- l_data  in  DATA_W  left pixel value
- l_eof  in  1  qualified by l_valid; marks last pixel of the left frame
- r_valid, r_addr, r_data, r_eof  in  same as left, right camera
- mem_we  out  1  frame RAM write enable
- mem_addr  out  ADDR_W+1  frame RAM write address
- mem_data  out  DATA_W  frame RAM write data
- pair_done  out  1  one-cycle pulse when both frames have completed
- l_ovf, r_ovf  out  1  sticky FIFO-overflow flags
- addr_err  out  1  sticky out-of-range address flag
- clr_flags  in  1  synchronous clear of all sticky flags

Behaviour:
- Reset (reset low, asynchronous):
  - FIFOs empty; mem_we=0, mem_addr=0, mem_data=0.
  - pair_done=0; all sticky flags 0.
  - Pair FSM in IDLE; last-grant register = RIGHT, so LEFT wins the first contention.
- Push:
  - On x_valid with x_addr < FRAME_WORDS and FIFO not full, push {eof, addr, data}.
  - If the FIFO is full: drop the pixel and set x_ovf.
  - If x_addr >= FRAME_WORDS: drop the pixel, set addr_err; no push, no ovf.
  - A dropped eof pixel does not advance the pair FSM.
- Arbitration, each cycle:
  - If exactly one FIFO is non-empty, grant it.
  - If both are non-empty, grant the port not granted last.
  - The grant pops one entry, and the last-grant register updates only on an actual grant.
- Output register:
  - Granted entry drives mem_we=1 and mem_data=data on the next cycle.
  - mem_addr = addr for LEFT; addr + FRAME_WORDS for RIGHT. Computed at ADDR_W+1 bits; no overflow, since addr < FRAME_WORDS.
  - mem_we=0 when nothing is granted; mem_addr and mem_data hold their values.
- Latency: valid pixel at edge N into an empty, uncontended FIFO → mem_we high after edge N+1 (2 cycles).
- Push and pop of the same FIFO in the same cycle are allowed when full: pop frees the slot and the push is accepted, no overflow.
- Pair FSM, advanced on the cycle an eof entry is written (mem_we with eof):
  - IDLE: left eof → L_DONE; right eof → R_DONE.
  - L_DONE: right eof → IDLE with pair_done=1; left eof → stay (newer left frame supersedes).
  - R_DONE: mirror of L_DONE.
  - pair_done is asserted in the same cycle as the mem_we of the completing write.
- clr_flags:
  - Clears the sticky flags.
  - If the same cycle also sets a flag, the set wins.
- Throughput: sustained combined input rate must be ≤1 pixel/cycle; bursts are absorbed up to FIFO_DEPTH per port.

Optional Feature:
- STEREO_ARB_DROP_CNT_EN defined:
  - Adds outputs l_drop_cnt and r_drop_cnt (16 bits each), counting dropped pixels per port from both overflow and address-error drops.
  - Counters saturate at 0xFFFF, reset to 0, and clear on clr_flags.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package stereo_arb_pkg: port-id enum {LEFT, RIGHT}; FIFO entry struct {eof, addr, data}; pair FSM state enum {IDLE, L_DONE, R_DONE}; FRAME_WORDS default constant.
- Sub-module pix_fifo: synchronous FIFO with full/empty and same-cycle push/pop, instantiated once per port.

Test Plan:
- Single left pixel, addr 5, data 0xAA, idle otherwise → two cycles later mem_we=1 for one cycle, mem_addr=5, mem_data=0xAA.
- Single right pixel, addr 5, data 0x3C → mem_addr=480005, mem_data=0x3C; no flags set.
- Both ports valid for 3 consecutive cycles, addrs L:0,1,2 and R:10,11,12 → writes in order L0, R10, L1, R11, L2, R12 with no gaps; ovf flags stay 0.
- Both ports valid for 12 consecutive cycles, FIFO_DEPTH=4 → at least one of l_ovf/r_ovf set; every written pixel's addr/data matches an accepted input; clr_flags clears the flags.
- Left eof pixel, then 20 cycles later right eof pixel → exactly one pair_done pulse, coincident with the right eof write. Repeat with left, left, right → exactly one pulse.
- Left pixel with addr 480000 → no mem_we, addr_err=1. Then assert reset while both FIFOs hold data → all outputs 0 immediately; no writes after release until new input arrives.
